// File: rtl/sensor_event_logger.sv
// sensor_event_logger: timestamps each rising edge of the detector event,
// stores {timestamp, sample} in a small FIFO and lets software drain it over
// a Wishbone classic slave with a single-cycle ack. The interrupt fires on a
// fill watermark or on overflow.
module sensor_event_logger #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cyc_i,
  input  logic             stb_i,
  input  logic             we_i,
  input  logic [3:0]       adr_i,
  input  logic [31:0]      dat_i,
  output logic [31:0]      dat_o,
  output logic             ack_o,
  output logic             irq_o,
  input  logic             event_i,
  input  logic [WIDTH-1:0] data_i
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  localparam logic [3:0] ADR_CTRL   = 4'h0;
  localparam logic [3:0] ADR_STATUS = 4'h1;
  localparam logic [3:0] ADR_WM     = 4'h2;
  localparam logic [3:0] ADR_POP    = 4'h3;
  localparam logic [3:0] ADR_DROPS  = 4'h4;
  localparam logic [3:0] ADR_TIME   = 4'h5;

  // FIFO storage; contents are don't-care until written, so no reset
  logic [31:0] mem [DEPTH];

  // Architectural state
  logic          enable;
  logic          irq_en;
  logic [7:0]    wm;
  logic [CW-1:0] count;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          overflow;
  logic [7:0]    drops;
  logic [15:0]   ts;
  logic          ev_q;

  // Next-state values
  logic          enable_next;
  logic          irq_en_next;
  logic [7:0]    wm_next;
  logic [CW-1:0] count_next;
  logic [PW-1:0] wr_ptr_next;
  logic [PW-1:0] rd_ptr_next;
  logic          overflow_next;
  logic [7:0]    drops_next;
  logic [7:0]    wm_eff_next;
  logic          irq_next;
  logic [31:0]   rdata;

  // Decoded strobes
  logic        acc;
  logic        wr_acc;
  logic        rd_acc;
  logic        empty;
  logic        full;
  logic        capture;
  logic        flush;
  logic        pop;
  logic        push_ok;
  logic        drop;
  logic [15:0] data_ext;

  assign data_ext = 16'(data_i);
  assign acc      = cyc_i & stb_i & ~ack_o;
  assign wr_acc   = acc & we_i;
  assign rd_acc   = acc & ~we_i;
  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign capture  = event_i & ~ev_q & enable;
  assign flush    = wr_acc & (adr_i == ADR_CTRL) & dat_i[2];
  assign pop      = rd_acc & (adr_i == ADR_POP) & ~empty;
  // A pop in the same cycle frees a slot first, so a full FIFO still accepts
  assign push_ok  = capture & ~flush & (~full | pop);
  assign drop     = capture & ~flush & full & ~pop;

  // Compute post-update register, FIFO and interrupt values
  always_comb begin
    enable_next   = enable;
    irq_en_next   = irq_en;
    wm_next       = wm;
    count_next    = count;
    wr_ptr_next   = wr_ptr;
    rd_ptr_next   = rd_ptr;
    overflow_next = overflow;
    drops_next    = drops;

    if (wr_acc && adr_i == ADR_CTRL) begin
      enable_next = dat_i[0];
      irq_en_next = dat_i[1];
    end
    if (wr_acc && adr_i == ADR_WM) begin
      wm_next = dat_i[7:0];
    end

    if (flush) begin
      count_next  = '0;
      wr_ptr_next = '0;
      rd_ptr_next = '0;
    end else begin
      if (push_ok) wr_ptr_next = wr_ptr + PW'(1);
      if (pop)     rd_ptr_next = rd_ptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   count_next = count + CW'(1);
        2'b01:   count_next = count - CW'(1);
        default: count_next = count;
      endcase
    end

    // A drop in the same cycle as the W1C keeps the flag set
    if (wr_acc && adr_i == ADR_STATUS && dat_i[10]) overflow_next = 1'b0;
    if (drop) overflow_next = 1'b1;

    if (wr_acc && adr_i == ADR_DROPS) begin
      drops_next = 8'd0;
    end else if (drop && drops != 8'hFF) begin
      drops_next = drops + 8'd1;
    end

    if (wm_next == 8'd0) begin
      wm_eff_next = 8'd1;
    end else if (wm_next > 8'(DEPTH)) begin
      wm_eff_next = 8'(DEPTH);
    end else begin
      wm_eff_next = wm_next;
    end

    irq_next = irq_en_next & ((8'(count_next) >= wm_eff_next) | overflow_next);
  end

  // Read data mux, sampled into dat_o at the accepting edge
  always_comb begin
    rdata = 32'd0;
    case (adr_i)
      ADR_CTRL:   rdata = {30'd0, irq_en, enable};
      ADR_STATUS: rdata = {21'd0, overflow, full, empty, 8'(count)};
      ADR_WM:     rdata = {24'd0, wm};
      ADR_POP:    rdata = empty ? 32'd0 : mem[rd_ptr];
      ADR_DROPS:  rdata = {24'd0, drops};
      ADR_TIME:   rdata = {16'd0, ts};
      default:    rdata = 32'd0;
    endcase
  end

  // State, bus handshake and interrupt registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable   <= 1'b0;
      irq_en   <= 1'b0;
      wm       <= 8'd1;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
      drops    <= 8'd0;
      ts       <= 16'd0;
      ev_q     <= 1'b0;
      ack_o    <= 1'b0;
      dat_o    <= 32'd0;
      irq_o    <= 1'b0;
    end else begin
      enable   <= enable_next;
      irq_en   <= irq_en_next;
      wm       <= wm_next;
      count    <= count_next;
      wr_ptr   <= wr_ptr_next;
      rd_ptr   <= rd_ptr_next;
      overflow <= overflow_next;
      drops    <= drops_next;
      ts       <= ts + 16'd1;
      ev_q     <= event_i;
      ack_o    <= acc;
      dat_o    <= rd_acc ? rdata : 32'd0;
      irq_o    <= irq_next;
    end
  end

  // FIFO write port: entry holds the timestamp and sample seen at the edge
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= {ts, data_ext};
    end
  end

endmodule

// File: tb/tb_sensor_event_logger.sv
// Self-checking bench for sensor_event_logger: register table first, then
// hand-written sequences for captures, overflow, aligned pop/flush, timestamp
// wrap and mid-operation reset.
module tb_sensor_event_logger;

  logic        clk;
  logic        rst_n;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  adr;
  logic [31:0] wdat;
  logic [31:0] rdat;
  logic        ack;
  logic        irq;
  logic        ev;
  logic [15:0] data;

  int checks   = 0;
  int failures = 0;
  int cyc_cnt  = 0;

  sensor_event_logger #(.WIDTH(16), .DEPTH(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cyc_i   (cyc),
    .stb_i   (stb),
    .we_i    (we),
    .adr_i   (adr),
    .dat_i   (wdat),
    .dat_o   (rdat),
    .ack_o   (ack),
    .irq_o   (irq),
    .event_i (ev),
    .data_i  (data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  typedef struct {
    logic        wr;
    logic [3:0]  a;
    logic [31:0] d;
    logic [31:0] exp;
    string       name;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // One Wishbone access: present at a falling edge, accepted at the next
  // rising edge, ack/data sampled at the following falling edge
  task automatic bus(input logic w, input logic [3:0] a, input logic [31:0] d,
                     output logic [31:0] r);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d;
    @(negedge clk);
    chk("ack", {31'd0, ack}, 32'd1);
    r = rdat;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    $display("txn %s adr=%0h wdat=%08h rdat=%08h", w ? "WR" : "RD", a, d, r);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] r;
    bus(1'b1, a, d, r);
  endtask

  task automatic rd_chk(input string name, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] r;
    bus(1'b0, a, 32'd0, r);
    chk(name, r, exp);
  endtask

  // One-cycle event pulse; returns the cycle index of the capture edge
  task automatic pulse(input logic [15:0] d, output int cap);
    @(negedge clk);
    ev = 1'b1; data = d;
    @(negedge clk);
    ev = 1'b0;
    cap = cyc_cnt;
    $display("txn EVENT data=%0d", d);
  endtask

  vec_t vecs[19];

  initial begin
    logic [31:0] r, r1, r2;
    int c1, c2, cdummy;

    vecs[0]  = '{1'b0, 4'h0, 32'h0,   32'h0,   "rst_ctrl"};
    vecs[1]  = '{1'b0, 4'h1, 32'h0,   32'h100, "rst_status"};
    vecs[2]  = '{1'b0, 4'h2, 32'h0,   32'h1,   "rst_wm"};
    vecs[3]  = '{1'b0, 4'h4, 32'h0,   32'h0,   "rst_drops"};
    vecs[4]  = '{1'b0, 4'h3, 32'h0,   32'h0,   "rst_pop_empty"};
    vecs[5]  = '{1'b0, 4'h7, 32'h0,   32'h0,   "unmapped_rd"};
    vecs[6]  = '{1'b1, 4'h0, 32'h3,   32'h0,   "wr_ctrl"};
    vecs[7]  = '{1'b0, 4'h0, 32'h0,   32'h3,   "ctrl_rb"};
    vecs[8]  = '{1'b1, 4'h0, 32'h7,   32'h0,   "wr_ctrl_flush"};
    vecs[9]  = '{1'b0, 4'h0, 32'h0,   32'h3,   "flush_selfclr"};
    vecs[10] = '{1'b1, 4'h2, 32'h1FF, 32'h0,   "wr_wm_wide"};
    vecs[11] = '{1'b0, 4'h2, 32'h0,   32'hFF,  "wm_8bit"};
    vecs[12] = '{1'b1, 4'h2, 32'h2,   32'h0,   "wr_wm"};
    vecs[13] = '{1'b0, 4'h2, 32'h0,   32'h2,   "wm_rb"};
    vecs[14] = '{1'b1, 4'h1, 32'h3FF, 32'h0,   "wr_status"};
    vecs[15] = '{1'b0, 4'h1, 32'h0,   32'h100, "status_ro"};
    vecs[16] = '{1'b1, 4'hF, 32'h55,  32'h0,   "wr_unmapped"};
    vecs[17] = '{1'b0, 4'hF, 32'h0,   32'h0,   "unmapped_rd2"};
    vecs[18] = '{1'b1, 4'h3, 32'h1234,32'h0,   "wr_pop_ign"};

    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 4'h0;
    wdat = 32'd0; ev = 1'b0; data = 16'd0;
    repeat (3) @(negedge clk);
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_dat", rdat, 32'd0);
    rst_n = 1'b1;

    // Register table
    for (int i = 0; i < 19; i++) begin
      bus(vecs[i].wr, vecs[i].a, vecs[i].d, r);
      if (!vecs[i].wr) chk(vecs[i].name, r, vecs[i].exp);
    end
    rd_chk("pop_wr_ignored", 4'h1, 32'h100);

    // Two captures with watermark 2
    pulse(16'd450, c1);
    chk("irq_below_wm", {31'd0, irq}, 32'd0);
    repeat (3) @(negedge clk);
    pulse(16'd500, c2);
    @(negedge clk);
    chk("irq_at_wm", {31'd0, irq}, 32'd1);
    rd_chk("status_cnt2", 4'h1, 32'h002);
    bus(1'b0, 4'h3, 32'd0, r1);
    chk("pop1_data", {16'd0, r1[15:0]}, 32'd450);
    chk("irq_after_pop", {31'd0, irq}, 32'd0);
    bus(1'b0, 4'h3, 32'd0, r2);
    chk("pop2_data", {16'd0, r2[15:0]}, 32'd500);
    chk("ts_spacing", {16'd0, 16'(r2[31:16] - r1[31:16])}, 32'(16'(c2 - c1)));

    // Held event gives one capture; watermark 0 acts as 1
    wr(4'h2, 32'h0);
    @(negedge clk);
    ev = 1'b1; data = 16'd77;
    repeat (20) @(negedge clk);
    ev = 1'b0;
    chk("irq_wm0", {31'd0, irq}, 32'd1);
    rd_chk("held_one", 4'h1, 32'h001);
    bus(1'b0, 4'h3, 32'd0, r);
    chk("held_data", {16'd0, r[15:0]}, 32'd77);

    // Disabled edges are ignored entirely
    wr(4'h0, 32'h2);
    pulse(16'd5, cdummy);
    rd_chk("dis_status", 4'h1, 32'h100);
    rd_chk("dis_drops", 4'h4, 32'h0);
    wr(4'h0, 32'h3);

    // Overflow with watermark above depth (acts as 8)
    wr(4'h2, 32'h9);
    for (int i = 0; i < 11; i++) begin
      pulse(16'(100 + i), cdummy);
      if (i == 6) chk("irq_cnt7", {31'd0, irq}, 32'd0);
      if (i == 7) chk("irq_cnt8", {31'd0, irq}, 32'd1);
    end
    rd_chk("ovf_status", 4'h1, 32'h608);
    rd_chk("ovf_drops", 4'h4, 32'h3);
    chk("ovf_irq", {31'd0, irq}, 32'd1);
    wr(4'h1, 32'h400);
    rd_chk("w1c_status", 4'h1, 32'h208);

    // Pop aligned with a capture on a full FIFO
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 4'h3;
    ev = 1'b1; data = 16'd200;
    @(negedge clk);
    chk("align_ack", {31'd0, ack}, 32'd1);
    chk("align_pop", {16'd0, rdat[15:0]}, 32'd100);
    cyc = 1'b0; stb = 1'b0; ev = 1'b0;
    $display("txn RD+EVENT adr=3 rdat=%08h", rdat);
    rd_chk("align_status", 4'h1, 32'h208);
    for (int i = 0; i < 8; i++) begin
      bus(1'b0, 4'h3, 32'd0, r);
      chk("drain_order", {16'd0, r[15:0]}, (i < 7) ? 32'(101 + i) : 32'd200);
    end
    rd_chk("drained", 4'h1, 32'h100);

    // Flush coinciding with a capture
    for (int i = 0; i < 5; i++) pulse(16'(300 + i), cdummy);
    rd_chk("five", 4'h1, 32'h005);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 4'h0; wdat = 32'h7;
    ev = 1'b1; data = 16'd999;
    @(negedge clk);
    chk("flush_ack", {31'd0, ack}, 32'd1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0; ev = 1'b0;
    $display("txn WR+EVENT adr=0 wdat=7");
    rd_chk("flush_status", 4'h1, 32'h100);
    rd_chk("flush_drops", 4'h4, 32'h3);
    rd_chk("flush_pop_empty", 4'h3, 32'h0);
    wr(4'h4, 32'h1);
    rd_chk("drops_clr", 4'h4, 32'h0);

    // Timestamp wrap, capture aligned with a TIME read
    bus(1'b0, 4'h5, 32'd0, r);
    repeat (int'(16'hFFFF - r[15:0]) + 20) @(negedge clk);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 4'h5;
    ev = 1'b1; data = 16'h1234;
    @(negedge clk);
    r1 = rdat;
    cyc = 1'b0; stb = 1'b0; ev = 1'b0;
    $display("txn RD+EVENT adr=5 rdat=%08h", r1);
    chk("time_wrapped", {31'd0, r1 < 32'd100}, 32'd1);
    rd_chk("wrap_entry", 4'h3, {r1[15:0], 16'h1234});

    // Reset in the middle of activity with an access pending
    wr(4'h2, 32'h5);
    for (int i = 0; i < 10; i++) pulse(16'(i), cdummy);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 4'h1;
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_ack", {31'd0, ack}, 32'd0);
    chk("mid_rst_irq", {31'd0, irq}, 32'd0);
    chk("mid_rst_dat", rdat, 32'd0);
    cyc = 1'b0; stb = 1'b0;
    rst_n = 1'b1;
    rd_chk("post_rst_ctrl", 4'h0, 32'h0);
    rd_chk("post_rst_status", 4'h1, 32'h100);
    rd_chk("post_rst_wm", 4'h2, 32'h1);
    rd_chk("post_rst_drops", 4'h4, 32'h0);
    rd_chk("post_rst_pop", 4'h3, 32'h0);
    bus(1'b0, 4'h5, 32'd0, r);
    chk("post_rst_time", {31'd0, r < 32'd16}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
